eth_mac_tx: RTL

Transmit-side Ethernet MAC framer. It takes a byte stream of frame contents (destination MAC through end of payload) from the UDP/MoldUDP64 packet builder. It drives a GMII-style byte interface into the RGMII DDR output stage on the `txDataOut`/`txCtrlOut` pins. It inserts the preamble and SFD, pads to the Ethernet minimum, appends the CRC-32 FCS and enforces the inter-frame gap. It is the counterpart of the RX path that terminates RGMII frames in `ethernet_to_book_top`.

---
 rtl/eth_mac_tx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/eth_mac_tx.sv
// eth_mac_tx: GMII transmit framer adding preamble/SFD, zero pad, CRC-32 FCS and inter-frame gap.
module eth_mac_tx #(
   parameter int IFG_CYCLES    = 12,
   parameter int MIN_FRAME_LEN = 60
) (
   input  logic       clkIn,
   input  logic       rstBIn,
   input  logic [7:0] dataIn,
   input  logic       validIn,
   input  logic       lastIn,
   output logic       readyOut,
   output logic [7:0] txDataOut,
   output logic       txEnOut,
   output logic       txErrOut,
   output logic       frameDoneOut
);
   typedef enum logic [3:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, ERR, DRAIN, IFG} state_t;
   localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME_LEN);
   localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);
   state_t      state_q;
   logic [15:0] cnt_q, cnt_d, sub_q;
   logic [31:0] crc_q, crc_d;
   logic [7:0]  crc_byte;

   function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
      return r;
   endfunction

   assign readyOut = (state_q == DATA) || (state_q == DRAIN);
   // Pad bytes feed zeros into the CRC; only DATA feeds the input byte.
   assign crc_byte = (state_q == DATA) ? dataIn : 8'h00;
   assign crc_d    = crc8(crc_q, crc_byte);
   assign cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   always_ff @(posedge clkIn or negedge rstBIn) begin
      if (!rstBIn) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sub_q        <= '0;
         crc_q        <= 32'hFFFFFFFF;
         txDataOut    <= 8'h00;
         txEnOut      <= 1'b0;
         txErrOut     <= 1'b0;
         frameDoneOut <= 1'b0;
      end else begin
         frameDoneOut <= 1'b0;
         txErrOut     <= 1'b0;
         case (state_q)
            IDLE: begin
               txEnOut   <= 1'b0;
               txDataOut <= 8'h00;
               crc_q     <= 32'hFFFFFFFF;
               if (validIn) begin
                  state_q <= PREAMBLE;
                  cnt_q   <= '0;
                  sub_q   <= '0;
               end
            end
            PREAMBLE: begin
               txEnOut   <= 1'b1;
               txDataOut <= 8'h55;
               sub_q     <= (sub_q == 16'd6) ? 16'd0 : sub_q + 16'd1;
               if (sub_q == 16'd6) state_q <= SFD;
            end
            SFD: begin
               txEnOut   <= 1'b1;
               txDataOut <= 8'hD5;
               state_q   <= DATA;
            end
            DATA: begin
               txEnOut <= 1'b1;
               if (validIn) begin
                  txDataOut <= dataIn;
                  crc_q     <= crc_d;
                  cnt_q     <= cnt_d;
                  if (lastIn) state_q <= (cnt_d < MIN_LEN) ? PAD : FCS;
               end else begin
                  // Underflow: hold TX_EN with a filler byte so the error cycle lands inside the frame.
                  txDataOut <= 8'h00;
                  state_q   <= ERR;
               end
            end
            PAD: begin
               txEnOut   <= 1'b1;
               txDataOut <= 8'h00;
               crc_q     <= crc_d;
               cnt_q     <= cnt_d;
               if (cnt_d >= MIN_LEN) state_q <= FCS;
            end
            FCS: begin
               txEnOut   <= 1'b1;
               txDataOut <= ~crc_q[{sub_q[1:0], 3'b000} +: 8];
               sub_q     <= (sub_q == 16'd3) ? 16'd0 : sub_q + 16'd1;
               if (sub_q == 16'd3) begin
                  frameDoneOut <= 1'b1;
                  state_q      <= IFG;
               end
            end
            ERR: begin
               txEnOut   <= 1'b1;
               txErrOut  <= 1'b1;
               txDataOut <= 8'h00;
               state_q   <= DRAIN;
            end
            DRAIN: begin
               txEnOut   <= 1'b0;
               txDataOut <= 8'h00;
               sub_q     <= '0;
               if (validIn && lastIn) state_q <= IFG;
            end
            IFG: begin
               txEnOut   <= 1'b0;
               txDataOut <= 8'h00;
               sub_q     <= (sub_q == IFG_LAST) ? 16'd0 : sub_q + 16'd1;
               if (sub_q == IFG_LAST) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
